// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEF = 4;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t IDLE = 2'd0;
  localparam mul_state_t RUN  = 2'd1;
  localparam mul_state_t DONE = 2'd2;

endpackage

// File: rtl/mul_pp_cell.sv
// Partial-product cell: passes the shifted multiplicand when the multiplier bit is set.
module mul_pp_cell
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
  input  logic               i_sel,
  input  logic [2*WIDTH-1:0] i_x,
  output logic [2*WIDTH-1:0] o_pp_c
);

  assign o_pp_c = i_sel ? i_x : '0;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier controller with start/busy/done handshake.
// Define MUL_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t     r_state;
  logic [PW-1:0]  r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]  r_acc;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_product;
  logic           r_busy;
  logic           r_done;

  mul_state_t     w_state_nxt;
  logic [PW-1:0]  w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [PW-1:0]  w_acc_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [PW-1:0]  w_product_nxt;
  logic [PW-1:0]  w_pp;
  logic [PW-1:0]  w_sum;

  mul_pp_cell #(.WIDTH(WIDTH)) u_pp (
    .i_sel  (r_mplier[0]),
    .i_x    (r_mcand),
    .o_pp_c (w_pp)
  );

  assign w_sum = r_acc + w_pp;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_acc_nxt     = r_acc;
    w_count_nxt   = r_count;
    w_product_nxt = r_product;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_mcand_nxt  = PW'(i_a);
          w_mplier_nxt = i_b;
          w_acc_nxt    = '0;
          w_count_nxt  = '0;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (r_mplier == '0) begin
          w_product_nxt = r_acc;
          w_state_nxt   = DONE;
        end else
`endif
        begin
          w_acc_nxt    = w_sum;
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_count_nxt  = r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            w_product_nxt = w_sum;
            w_state_nxt   = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track r_state exactly
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_acc     <= w_acc_nxt;
      r_count   <= w_count_nxt;
      r_product <= w_product_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH=4); honours MUL_SEQ_EARLY_TERM_EN.
module tb_mul_seq_ctrl;

  localparam int unsigned W = 4;

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam int LAT_B0 = 1;
  localparam int LAT_B1 = 2;
  localparam int LAT_B2 = 3;
`else
  localparam int LAT_B0 = 4;
  localparam int LAT_B1 = 4;
  localparam int LAT_B2 = 4;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           o_busy;
  logic           o_done;
  logic [2*W-1:0] o_product;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: latency counted in edges after the accepting edge E0
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_p, input int exp_lat);
    int lat;
    lat = 0;
    i_start = 1'b1; i_a = a; i_b = b;
    step();
    i_start = 1'b0;
    chk({tag, "_busy_e0"}, 32'(o_busy), 32'd1);
    chk({tag, "_done_e0"}, 32'(o_done), 32'd0);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (o_done) lat = k;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(o_product), 32'(exp_p));
    chk({tag, "_busy_done"}, 32'(o_busy), 32'd1);
    step();
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(o_busy), 32'd0);
    chk({tag, "_prod_hold"}, 32'(o_product), 32'(exp_p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int gap;
    int idle_cyc;
    int hold_bad;
    int pulses;

    reset = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0;
    step(); step();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_prod", 32'(o_product), 32'd0);
    reset = 1'b1;
    step();

    run_op("zero",  4'd0,  4'd0,  0,   LAT_B0);
    run_op("max",   4'd15, 4'd15, 225, 4);
    run_op("b1",    4'd9,  4'd1,  9,   LAT_B1);
    run_op("b8",    4'd9,  4'd8,  72,  4);
    run_op("b2",    4'd5,  4'd2,  10,  LAT_B2);

    // Back-to-back with start held high; new operands presented during RUN
    i_start = 1'b1; i_a = 4'd13; i_b = 4'd11;
    step();
    i_a = 4'd7; i_b = 4'd9;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (o_done) lat = k;
    end
    chk("b2b_lat1", 32'(lat), 32'd4);
    chk("b2b_prod1", 32'(o_product), 32'd143);
    gap = 0; idle_cyc = 0; hold_bad = 0;
    for (int k = 1; k <= 20 && gap == 0; k++) begin
      step();
      if (o_done) gap = k;
      else begin
        if (!o_busy) idle_cyc++;
        if (o_product != 8'd143) hold_bad++;
      end
    end
    i_start = 1'b0;
    chk("b2b_gap", 32'(gap), 32'(W + 2));
    chk("b2b_idle", 32'(idle_cyc), 32'd1);
    chk("b2b_hold", 32'(hold_bad), 32'd0);
    chk("b2b_prod2", 32'(o_product), 32'd63);
    step();
    chk("b2b_end_busy", 32'(o_busy), 32'd0);
    step();

    // start and operands wiggled during RUN must not disturb the captured operation
    i_start = 1'b1; i_a = 4'd13; i_b = 4'd11;
    step();
    i_a = 4'd2; i_b = 4'd3;
    step();
    i_a = 4'd5; i_b = 4'd6;
    step();
    i_start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20 && lat == 0; k++) begin
      step();
      if (o_done) lat = k;
    end
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_prod", 32'(o_product), 32'd143);
    step();
    chk("ign_idle", 32'(o_busy), 32'd0);

    // Reset asserted at E2 of an operation aborts it with no done
    i_start = 1'b1; i_a = 4'd15; i_b = 4'd15;
    step();
    i_start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_prod", 32'(o_product), 32'd0);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op("post_rst", 4'd6, 4'd7, 42, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
